// File: rtl/cordic_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cordic_top
// Brief   : IEEE-754 degrees in, Q1.15 sin/cos out via 16-step rotation CORDIC.
// Revision: 1.0
// ============================================================================
module cordic_top (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [31:0]        angle_ieee754,
    output logic signed [15:0] sin_ieee754,
    output logic signed [15:0] cos_ieee754,
    output logic               valid,
    output logic signed [2:0]  flip_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CONV   = 3'd1;
    localparam logic [2:0] S_REDUCE = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [25:0]        C_720     = 26'd47185920;
    localparam logic [25:0]        C_360     = 26'd23592960;
    localparam logic [25:0]        C_270     = 26'd17694720;
    localparam logic [25:0]        C_180     = 26'd11796480;
    localparam logic [25:0]        C_90      = 26'd5898240;
    localparam logic [43:0]        C_DEG2RAD = 44'd585635;   // pi/90 * 2^24
    localparam logic [43:0]        C_RND24   = 44'd8388608;
    localparam logic signed [19:0] C_K       = 20'sd79594;

    logic [2:0]         state_q, state_d;
    logic               armed_q, armed_d;
    logic [31:0]        angle_q, angle_d;
    logic               neg_q, neg_d;
    logic [25:0]        fix_q, fix_d;
    logic [1:0]         quad_q, quad_d;
    logic signed [19:0] x_q, x_d;
    logic signed [19:0] y_q, y_d;
    logic signed [19:0] z_q, z_d;
    logic [3:0]         iter_q, iter_d;
    logic signed [15:0] sin_q, sin_d;
    logic signed [15:0] cos_q, cos_d;
    logic signed [2:0]  flip_q, flip_d;
    logic               valid_q, valid_d;

    logic [7:0]         w_exp;
    logic [25:0]        w_mant;
    logic               w_conv_ok;
    logic [25:0]        w_fix;
    logic               w_neg;

    logic [25:0]        w_a1, w_a2, w_base;
    logic [1:0]         w_quad;
    logic [22:0]        w_r;
    logic [43:0]        w_prod;
    logic signed [19:0] w_rad;

    logic signed [19:0] w_xs, w_ys, w_atan;
    logic               w_zpos;

    logic signed [20:0] w_sr, w_cr, w_s, w_c;

    function automatic logic signed [15:0] to_q15(input logic signed [20:0] v);
        logic signed [20:0] s;
        s = (v + 21'sd2) >>> 2;
        if (s > 21'sd32767)
            to_q15 = 16'sh7FFF;
        else if (s < -21'sd32768)
            to_q15 = 16'sh8000;
        else
            to_q15 = 16'(s);
    endfunction

    // Float to unsigned 10.16 fixed point; unsupported encodings collapse to 0 deg.
    always_comb begin
        w_exp     = angle_q[30:23];
        w_mant    = {3'b001, angle_q[22:0]};
        w_conv_ok = (w_exp != 8'd0) && (w_exp < 8'd137);
        if (!w_conv_ok)
            w_fix = '0;
        else if (w_exp >= 8'd134)
            w_fix = w_mant << (w_exp - 8'd134);
        else
            w_fix = w_mant >> (8'd134 - w_exp);
        w_neg = angle_q[31] & w_conv_ok;
    end

    always_comb begin
        w_a1 = (fix_q >= C_720) ? (fix_q - C_720) : fix_q;
        w_a2 = (w_a1 >= C_360) ? (w_a1 - C_360) : w_a1;
        if (w_a2 >= C_270) begin
            w_quad = 2'd3;
            w_base = C_270;
        end else if (w_a2 >= C_180) begin
            w_quad = 2'd2;
            w_base = C_180;
        end else if (w_a2 >= C_90) begin
            w_quad = 2'd1;
            w_base = C_90;
        end else begin
            w_quad = 2'd0;
            w_base = '0;
        end
        w_r    = 23'(w_a2 - w_base);
        w_prod = {21'd0, w_r} * C_DEG2RAD;
        w_rad  = 20'((w_prod + C_RND24) >> 24);
    end

    always_comb begin
        w_xs   = x_q >>> iter_q;
        w_ys   = y_q >>> iter_q;
        w_zpos = ~z_q[19];
        w_atan = 20'sd0;
        case (iter_q)
            4'd0:  w_atan = 20'sd102944;
            4'd1:  w_atan = 20'sd60771;
            4'd2:  w_atan = 20'sd32110;
            4'd3:  w_atan = 20'sd16299;
            4'd4:  w_atan = 20'sd8181;
            4'd5:  w_atan = 20'sd4095;
            4'd6:  w_atan = 20'sd2048;
            4'd7:  w_atan = 20'sd1024;
            4'd8:  w_atan = 20'sd512;
            4'd9:  w_atan = 20'sd256;
            4'd10: w_atan = 20'sd128;
            4'd11: w_atan = 20'sd64;
            4'd12: w_atan = 20'sd32;
            4'd13: w_atan = 20'sd16;
            4'd14: w_atan = 20'sd8;
            4'd15: w_atan = 20'sd4;
            default: w_atan = 20'sd0;
        endcase
    end

    // Unfold first-quadrant result back to the original quadrant and sign.
    always_comb begin
        w_sr = {y_q[19], y_q};
        w_cr = {x_q[19], x_q};
        case (quad_q)
            2'd0: begin w_s = w_sr;  w_c = w_cr;  end
            2'd1: begin w_s = w_cr;  w_c = -w_sr; end
            2'd2: begin w_s = -w_sr; w_c = -w_cr; end
            default: begin w_s = -w_cr; w_c = w_sr; end
        endcase
        if (neg_q)
            w_s = -w_s;
    end

    always_comb begin
        state_d = state_q;
        armed_d = 1'b1;
        angle_d = angle_q;
        neg_d   = neg_q;
        fix_d   = fix_q;
        quad_d  = quad_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        flip_d  = flip_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // armed_q blocks a strobe on the first edge after reset release
                if (valid_in && armed_q) begin
                    angle_d = angle_ieee754;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                fix_d   = w_fix;
                neg_d   = w_neg;
                state_d = S_REDUCE;
            end
            S_REDUCE: begin
                quad_d  = w_quad;
                x_d     = C_K;
                y_d     = 20'sd0;
                z_d     = w_rad;
                iter_d  = 4'd0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (w_zpos) begin
                    x_d = x_q - w_ys;
                    y_d = y_q + w_xs;
                    z_d = z_q - w_atan;
                end else begin
                    x_d = x_q + w_ys;
                    y_d = y_q - w_xs;
                    z_d = z_q + w_atan;
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15)
                    state_d = S_DONE;
            end
            S_DONE: begin
                sin_d   = to_q15(w_s);
                cos_d   = to_q15(w_c);
                flip_d  = {neg_q, quad_q};
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            angle_q <= '0;
            neg_q   <= 1'b0;
            fix_q   <= '0;
            quad_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            flip_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            angle_q <= angle_d;
            neg_q   <= neg_d;
            fix_q   <= fix_d;
            quad_q  <= quad_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            flip_q  <= flip_d;
            valid_q <= valid_d;
        end
    end

    assign sin_ieee754 = sin_q;
    assign cos_ieee754 = cos_q;
    assign flip_out    = flip_q;
    assign valid       = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_cordic_top
// Brief   : Directed and random angles against a real-arithmetic sin/cos model.
// Revision: 1.0
// ============================================================================
module tb_cordic_top;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic [31:0]        angle;
    logic signed [15:0] sin_o;
    logic signed [15:0] cos_o;
    logic               valid_o;
    logic signed [2:0]  flip_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_top dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .angle_ieee754 (angle),
        .sin_ieee754   (sin_o),
        .cos_ieee754   (cos_o),
        .valid         (valid_o),
        .flip_out      (flip_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [15:0] obs, input real exp);
        real  err;
        logic ok;
        err = real'(obs) / 32768.0 - exp;
        ok  = (err <= 5.0e-4) && (err >= -5.0e-4);
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected~%0d (%f)", tag, obs, $rtoi(exp * 32768.0), exp);
        end
    endtask

    function automatic logic [31:0] int2bits(input int n);
        int unsigned mag;
        int          p;
        if (n == 0) return 32'h0;
        mag = (n < 0) ? -n : n;
        p   = 0;
        for (int k = 0; k < 31; k++)
            if ((mag >> k) != 0) p = k;
        return {(n < 0) ? 1'b1 : 1'b0, 8'(127 + p), 23'(mag << (23 - p))};
    endfunction

    // Reference: true sin/cos of the float angle; unsupported encodings behave as 0 deg.
    task automatic ref_model(input logic [31:0] b, output real s, output real c,
                             output logic [2:0] f);
        int  e;
        real v, a, rad;
        int  q;
        e = int'(b[30:23]);
        v = 0.0;
        if (e != 0 && e != 255)
            v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
        if (e == 0 || e == 255 || v >= 1024.0) begin
            s = 0.0;
            c = 1.0;
            f = 3'b000;
        end else begin
            a = v;
            q = 0;
            while (a >= 360.0) a = a - 360.0;
            while (a >= 90.0) begin
                a = a - 90.0;
                q++;
            end
            rad = v * PI / 180.0;
            if (b[31]) rad = -rad;
            s = $sin(rad);
            c = $cos(rad);
            f = {b[31], 2'(q)};
        end
    endtask

    task automatic strobe(input logic [31:0] b);
        @(negedge clk);
        angle    = b;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] b);
        real        s, c;
        logic [2:0] f;
        int         lat;
        ref_model(b, s, c, f);
        strobe(b);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_o) break;
        end
        chk({tag, "_latency"}, lat, 19);
        chk_near({tag, "_sin"}, sin_o, s);
        chk_near({tag, "_cos"}, cos_o, c);
        chk({tag, "_flip"}, {29'd0, flip_o}, {29'd0, f});
        @(posedge clk);
        #1;
        chk({tag, "_valid_pulse"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        logic signed [15:0] s400, c400;
        logic [31:0]        b;
        int                 nv, lat;

        rst      = 1'b0;
        valid_in = 1'b0;
        angle    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sin",   {16'd0, sin_o}, 32'd0);
        chk("reset_cos",   {16'd0, cos_o}, 32'd0);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_flip",  {29'd0, flip_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run_case("deg0",    32'h00000000);
        run_case("deg30",   32'h41F00000);
        run_case("deg90",   32'h42B40000);
        run_case("deg180",  32'h43340000);
        run_case("deg270",  32'h43870000);
        run_case("degm45",  32'hC2340000);
        run_case("deg400",  32'h43C80000);
        s400 = sin_o;
        c400 = cos_o;
        run_case("deg40",   32'h42200000);
        chk("deg400_eq_40_sin", {16'd0, sin_o}, {16'd0, s400});
        chk("deg400_eq_40_cos", {16'd0, cos_o}, {16'd0, c400});
        run_case("nan",     32'h7FC00000);
        run_case("ninf",    32'hFF800000);
        run_case("deg1024", 32'h44800000);
        run_case("deg1023", 32'h447FE000);
        run_case("mzero",   32'h80000000);
        run_case("denorm",  32'h80000001);
        run_case("deg_m719", 32'hC433C000);

        run_case("hold", 32'h42700000);
        repeat (6) @(posedge clk);
        #1;
        chk_near("hold_sin", sin_o, $sin(60.0 * PI / 180.0));
        chk_near("hold_cos", cos_o, $cos(60.0 * PI / 180.0));

        for (int d = 0; d < 360; d++)
            run_case($sformatf("sweep%0d", d), int2bits(d));

        for (int i = 0; i < 80; i++) begin
            b = {1'($urandom), 8'($urandom_range(137, 112)), 23'($urandom)};
            run_case($sformatf("rand%0d_%08h", i, b), b);
        end

        // Reset asserted eight cycles into a computation
        run_case("pre_abort", 32'h41F00000);
        strobe(32'h42700000);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_sin",   {16'd0, sin_o}, 32'd0);
        chk("abort_cos",   {16'd0, cos_o}, 32'd0);
        chk("abort_valid", {31'd0, valid_o}, 32'd0);
        chk("abort_flip",  {29'd0, flip_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nv  = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid_o) nv++;
        end
        chk("abort_no_valid", nv, 0);

        // Second strobe while busy must be ignored
        strobe(32'h41F00000);
        nv  = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                nv++;
                if (lat == 0) begin
                    lat = cyc;
                    chk_near("busy_sin", sin_o, 0.5);
                    chk("busy_flip", {29'd0, flip_o}, 32'd0);
                end
            end
            if (cyc == 5) begin
                @(negedge clk);
                angle    = 32'h42700000;
                valid_in = 1'b1;
            end
            if (cyc == 6) begin
                @(negedge clk);
                valid_in = 1'b0;
            end
        end
        chk("busy_one_valid", nv, 1);
        chk("busy_latency", lat, 19);

        // Strobe on the first edge after reset release must be ignored
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        angle    = 32'h41F00000;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        nv = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid_o) nv++;
        end
        chk("release_no_valid", nv, 0);
        chk("release_cos_zero", {16'd0, cos_o}, 32'd0);
        run_case("after_release", 32'h43960000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cordic_top.md
# cordic_top

Fixed-latency sine/cosine generator. Takes an angle in degrees as an IEEE-754 single-precision word and returns sin and cos as signed Q1.15 words. Internally it converts the float to fixed point, reduces it modulo 360°, folds it into the first quadrant and runs a 16-iteration rotation-mode CORDIC. It is the top of the CORDIC datapath and is driven by a simple valid pulse.

## Interface
- Parameters: none. Iterations fixed at 16; internal datapath 20-bit signed with 17 fractional bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `valid_in` in 1: one-cycle start strobe; `angle_ieee754` is sampled on the same edge.
- `angle_ieee754` in 32: angle in degrees, IEEE-754 single precision.
- `sin_ieee754` out 16 signed: sin(angle), Q1.15 two's complement. This is not an IEEE format despite the name.
- `cos_ieee754` out 16 signed: cos(angle), Q1.15.
- `valid` out 1: one-cycle result strobe.
- `flip_out` out 3 signed: fold code {neg, q[1:0]}.
  - neg = input sign bit.
  - q = quadrant of |angle| mod 360 (0: [0,90), 1: [90,180), 2: [180,270), 3: [270,360)).

## Operation
- FSM states: IDLE → CONV → REDUCE → ITER (16 cycles) → DONE → IDLE.
- `valid_in` is accepted only in IDLE and ignored while busy.
- **CONV**
  - Converts |angle| to unsigned fixed point: 10 integer bits, 16 fraction bits, mantissa shifted by the exponent.
  - Zero, denormal, NaN, ±inf, or |angle| ≥ 1024 → treated as 0° with neg = 0.
- **REDUCE**
  - Subtract 720 if ≥ 720, then 360 if ≥ 360.
  - q = floor(a/90); r = a − 90q, in [0,90).
  - Convert r to radians in Q2.17 by multiplying by the constant π/180.
- **ITER**
  - Initial values: x0 = K = 79594 (0.6072529·2^17), y0 = 0, z0 = r.
  - Iteration i = 0..15, with d = sign(z) (+1 when z ≥ 0):
    - x −= d·(y>>>i)
    - y += d·(x>>>i)
    - z −= d·atan_tab[i]
  - atan_tab[i] = round(atan(2^−i)·2^17).
- **DONE**
  - Quadrant mapping from sr = y, cr = x:
    - q0: (sin, cos) = (sr, cr)
    - q1: (cr, −sr)
    - q2: (−sr, −cr)
    - q3: (−cr, sr)
  - If neg, negate sin.
  - Convert Q17 → Q15 by adding 2 and arithmetic-shifting right by 2.
  - Saturate to [−32768, 32767]. +1.0 gives 0x7FFF; −1.0 gives 0x8000.
  - Register sin, cos and flip_out; pulse `valid`.
- Accuracy: |result/32768 − true value| ≤ 5e-4 for every supported angle.

## Timing
- Reset (rst = 0, asynchronous):
  - `sin_ieee754` = 0, `cos_ieee754` = 0, `valid` = 0, `flip_out` = 0; FSM = IDLE.
  - Asserting reset mid-operation aborts the computation; no `valid` follows.
- `valid_in` sampled high at edge E0 → CONV at E1, REDUCE at E2, ITER at E3..E18, outputs registered at E19.
- `valid` is high for exactly one cycle after E19, i.e. a latency of 19 cycles.
- Outputs hold their last result until the next DONE or reset.
- A new `valid_in` is accepted on the cycle after `valid` at the earliest; `valid_in` held high longer starts only one computation per IDLE visit.
- `valid_in` coincident with reset release is ignored.

## Test plan
- 0° (0x00000000) → sin 0x0000 ±16, cos 0x7FFF ±16, flip_out 0, valid exactly 19 cycles after the strobe.
- 30° (0x41F00000) → sin ≈ 0x4000, cos ≈ 0x6ED9 (±16 LSB); 90° (0x42B40000) → sin 0x7FFF (saturated), cos ≈ 0, flip_out 1.
- 180° (0x43340000) → sin ≈ 0, cos ≈ 0x8000, flip_out 2; 270° (0x43870000) → sin ≈ 0x8000, flip_out 3.
- −45° (0xC2340000) → sin ≈ 0xA57E, cos ≈ 0x5A82, flip_out 3'b100 (−4); 400° (0x43C80000) → same result as 40° (sin ≈ 0x5247, cos ≈ 0x620E).
- Sweep 0..359° integers against reference sin/cos → every |error| ≤ 5e-4. NaN (0x7FC00000) → sin 0, cos 0x7FFF.
- Reset pulsed at cycle 8 of a computation → all outputs 0, no `valid`. `valid_in` re-pulsed at cycle 5 → ignored, exactly one `valid`.
